// File: rtl/dds_wave_gen_if.sv
// dds_wave_gen_if: control and sample bundle between the register block, the
// DDS waveform generator and the DAC output stage.
//
// Optional feature macro: DDS_AMP_SCALE_EN adds the amp (gain) signal.
//
// Signals
//   en         accumulator advance enable
//   freq       tuning word (phase increment per enabled cycle)
//   freq_ld    1-cycle strobe capturing freq/form/duty into the pending set
//   form       waveform select
//   duty       pulse threshold for the pulse waveform
//   phase_clr  synchronous phase clear
//   amp        unsigned gain (DDS_AMP_SCALE_EN only)
//   dds        output sample (unsigned offset binary)
//   dds_valid  dds holds a sample computed from an enabled cycle
//   wrap       1-cycle pulse on accumulator carry-out
//
// Modports: master drives the controls and reads the samples; slave is the generator.
interface dds_wave_gen_if #(
    parameter int PHASE_W = 32,
    parameter int OUT_W   = 8
);
    logic               en;
    logic [PHASE_W-1:0] freq;
    logic               freq_ld;
    logic [2:0]         form;
    logic [OUT_W-1:0]   duty;
    logic               phase_clr;
`ifdef DDS_AMP_SCALE_EN
    logic [OUT_W-1:0]   amp;
`endif
    logic [OUT_W-1:0]   dds;
    logic               dds_valid;
    logic               wrap;

`ifdef DDS_AMP_SCALE_EN
    modport master (output en, freq, freq_ld, form, duty, phase_clr, amp,
                    input  dds, dds_valid, wrap);
    modport slave  (input  en, freq, freq_ld, form, duty, phase_clr, amp,
                    output dds, dds_valid, wrap);
`else
    modport master (output en, freq, freq_ld, form, duty, phase_clr,
                    input  dds, dds_valid, wrap);
    modport slave  (input  en, freq, freq_ld, form, duty, phase_clr,
                    output dds, dds_valid, wrap);
`endif
endinterface

// File: rtl/dds_wave_gen.sv
// dds_wave_gen: DDS waveform generator. A phase accumulator feeds a registered
// shaper. The shaper produces saw, reverse saw, triangle, square and pulse
// waveforms as unsigned offset-binary samples. Frequency, form and duty changes
// go to a pending set first. They become active only at a phase wrap, on
// phase clear, or while the accumulator is idle. As a result the waveform
// never glitches mid-period.
//
// Optional feature macro: DDS_AMP_SCALE_EN. When it is defined, the shaped
// sample is multiplied by bus.amp and truncated (>> OUT_W) in one extra
// register stage. This adds one cycle of latency to dds/dds_valid; wrap is
// unchanged.
//
// Ports
//   clk    system clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    dds_wave_gen_if.slave (controls in, dds/dds_valid/wrap out)
module dds_wave_gen #(
    parameter int PHASE_W = 32,
    parameter int OUT_W   = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    dds_wave_gen_if.slave  bus
);
    localparam logic [2:0] FORM_SAW = 3'b000;
    localparam logic [2:0] FORM_REV = 3'b001;
    localparam logic [2:0] FORM_TRI = 3'b010;
    localparam logic [2:0] FORM_SQR = 3'b011;
    localparam logic [2:0] FORM_PUL = 3'b100;

    localparam logic [OUT_W-1:0]   SAMPLE_MAX  = {OUT_W{1'b1}};
    localparam logic [OUT_W-1:0]   SAMPLE_ZERO = {OUT_W{1'b0}};
    // The reset duty is 25 %: only bit OUT_W-2 is set.
    localparam logic [OUT_W-1:0]   DUTY_RST    = {2'b01, {(OUT_W-2){1'b0}}};
    localparam logic [PHASE_W-1:0] PHASE_ZERO  = {PHASE_W{1'b0}};

    // Map one phase sample p (the top bits of the accumulator) to an output sample.
    function automatic logic [OUT_W-1:0] shape(input logic [OUT_W-1:0] p,
                                               input logic [2:0]       form,
                                               input logic [OUT_W-1:0] duty);
        logic [OUT_W-1:0] q;
        q = {p[OUT_W-2:0], 1'b0};
        case (form)
            FORM_SAW: shape = p;
            FORM_REV: shape = SAMPLE_MAX - p;
            // Rising half doubles p; falling half mirrors it by inverting.
            FORM_TRI: shape = p[OUT_W-1] ? ~q : q;
            FORM_SQR: shape = p[OUT_W-1] ? SAMPLE_MAX : SAMPLE_ZERO;
            FORM_PUL: shape = (p < duty) ? SAMPLE_MAX : SAMPLE_ZERO;
            default:  shape = SAMPLE_ZERO;
        endcase
    endfunction

    logic [PHASE_W-1:0] acc_r;
    logic [PHASE_W-1:0] freq_act_r;
    logic [PHASE_W-1:0] freq_pend_r;
    logic [2:0]         form_act_r;
    logic [2:0]         form_pend_r;
    logic [OUT_W-1:0]   duty_act_r;
    logic [OUT_W-1:0]   duty_pend_r;
    logic               wrap_r;
    logic [OUT_W-1:0]   dds_r;
    logic               dds_valid_r;

    logic [PHASE_W:0]   sum_s;
    logic [PHASE_W-1:0] acc_next_s;
    logic               wrap_next_s;
    logic               copy_s;
    logic               adv_s;
    logic [OUT_W-1:0]   shaped_s;

    // Compute the next accumulator value, the carry, the pending-to-active copy condition and the shaped sample.
    always_comb begin
        sum_s    = {1'b0, acc_r} + {1'b0, freq_act_r};
        adv_s    = bus.en & ~bus.phase_clr;
        shaped_s = shape(acc_r[PHASE_W-1 -: OUT_W], form_act_r, duty_act_r);
        if (bus.phase_clr) begin
            acc_next_s  = PHASE_ZERO;
            wrap_next_s = 1'b0;
            copy_s      = 1'b1;
        end else if (bus.en) begin
            acc_next_s  = sum_s[PHASE_W-1:0];
            wrap_next_s = sum_s[PHASE_W];
            copy_s      = sum_s[PHASE_W];
        end else begin
            // While idle, each cycle is a safe point to take new settings.
            acc_next_s  = acc_r;
            wrap_next_s = 1'b0;
            copy_s      = 1'b1;
        end
    end

    // Phase accumulator and the wrap pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_r  <= PHASE_ZERO;
            wrap_r <= 1'b0;
        end else begin
            acc_r  <= acc_next_s;
            wrap_r <= wrap_next_s;
        end
    end

    // Pending/active settings. On a copy the active set takes the old pending value, so a coinciding load waits for the next copy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            freq_pend_r <= PHASE_ZERO;
            form_pend_r <= FORM_SAW;
            duty_pend_r <= DUTY_RST;
            freq_act_r  <= PHASE_ZERO;
            form_act_r  <= FORM_SAW;
            duty_act_r  <= DUTY_RST;
        end else begin
            if (bus.freq_ld) begin
                freq_pend_r <= bus.freq;
                form_pend_r <= bus.form;
                duty_pend_r <= bus.duty;
            end
            if (copy_s) begin
                freq_act_r <= freq_pend_r;
                form_act_r <= form_pend_r;
                duty_act_r <= duty_pend_r;
            end
        end
    end

    // Shaper output register. The sample is held when no enabled cycle produced a new one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dds_r       <= SAMPLE_ZERO;
            dds_valid_r <= 1'b0;
        end else begin
            dds_valid_r <= adv_s;
            if (adv_s) begin
                dds_r <= shaped_s;
            end
        end
    end

`ifdef DDS_AMP_SCALE_EN
    logic [2*OUT_W-1:0] prod_s;
    logic [OUT_W-1:0]   dds_amp_r;
    logic               dds_amp_valid_r;

    assign prod_s = {{OUT_W{1'b0}}, dds_r} * {{OUT_W{1'b0}}, bus.amp};

    // Gain stage: keep the upper half of the product (truncating >> OUT_W).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dds_amp_r       <= SAMPLE_ZERO;
            dds_amp_valid_r <= 1'b0;
        end else begin
            dds_amp_r       <= prod_s[2*OUT_W-1:OUT_W];
            dds_amp_valid_r <= dds_valid_r;
        end
    end

    assign bus.dds       = dds_amp_r;
    assign bus.dds_valid = dds_amp_valid_r;
`else
    assign bus.dds       = dds_r;
    assign bus.dds_valid = dds_valid_r;
`endif
    assign bus.wrap = wrap_r;

endmodule
